// File: rtl/data_memory_unit.sv
// Multi-cycle MEM-stage data memory: byte/halfword/word loads and stores with
// optional sign extension, configurable wait states and a Busy/Done/Fault handshake.
module data_memory_unit #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        Busy,
  output logic        Done,
  output logic        Fault
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_q, wr_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdat_q;
  logic [31:0] dout_q, dout_d;
  logic        fault_q, fault_d;
  logic        capture, do_access;

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic        acc_rd, acc_wr, acc_sext, acc_fault;
  logic [1:0]  acc_size, lane;
  logic [31:0] acc_addr, acc_wdat;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word, ld_val, wr_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be;

  // With no wait states the access happens on the accept edge, so it must
  // use the live inputs; otherwise it uses the request captured at accept.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_rd = MemRd;  acc_wr = MemWr;  acc_size = Size;
      acc_sext = SignExt;  acc_addr = Address;  acc_wdat = Data_in;
    end else begin
      acc_rd = rd_q;  acc_wr = wr_q;  acc_size = size_q;
      acc_sext = sext_q;  acc_addr = addr_q;  acc_wdat = wdat_q;
    end
  end

  assign word_idx = acc_addr[AW+1:2];
  assign lane     = acc_addr[1:0];
  assign rd_word  = mem_q[word_idx];
  assign ld_byte  = rd_word[{lane, 3'b000} +: 8];
  assign ld_half  = rd_word[{lane[1], 4'b0000} +: 16];

  assign acc_fault = (acc_rd & acc_wr)
                   | (acc_size == 2'b11)
                   | ((acc_size == 2'b01) & acc_addr[0])
                   | ((acc_size == 2'b10) & (|acc_addr[1:0]))
                   | (|acc_addr[31:AW+2]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ld_val  = rd_word;
    be      = 4'b0000;
    wr_word = acc_wdat;
    case (acc_size)
      2'b00: begin
        ld_val  = {{24{acc_sext & ld_byte[7]}}, ld_byte};
        be      = 4'b0001 << lane;
        wr_word = {4{acc_wdat[7:0]}};
      end
      2'b01: begin
        ld_val  = {{16{acc_sext & ld_half[15]}}, ld_half};
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{acc_wdat[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: if (MemRd | MemWr) begin
        capture = 1'b1;
        if (WAIT_STATES == 0) begin
          state_d   = S_DONE;
          do_access = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: if (cnt_q == 3'd0) begin
        state_d   = S_DONE;
        do_access = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    fault_d = 1'b0;
    if (do_access) begin
      fault_d = acc_fault;
      if (acc_fault)   dout_d = '0;
      else if (acc_rd) dout_d = ld_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      fault_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      fault_q <= fault_d;
      if (capture) begin
        rd_q   <= MemRd;
        wr_q   <= MemWr;
        sext_q <= SignExt;
        size_q <= Size;
        addr_q <= Address;
        wdat_q <= Data_in;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (do_access && acc_wr && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign Data_out = dout_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign Fault    = fault_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: three instances (WS=1, 0, 3) checked against a
// byte-array reference model, with directed plan cases and random traffic.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_rd = 1'b0, req_wr = 1'b0, req_sext = 1'b0;
  logic [1:0]  req_size = 2'b00, sel = 2'b00;
  logic [31:0] req_addr = '0, req_din = '0;
  logic [31:0] dout0, dout1, dout2;
  logic [2:0]  busy, done, fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mm [3][256];
  logic [31:0] exp_dout [3];

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH(64), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .MemRd(req_rd && sel == 2'd0), .MemWr(req_wr && sel == 2'd0),
    .Size(req_size), .SignExt(req_sext), .Address(req_addr), .Data_in(req_din),
    .Data_out(dout0), .Busy(busy[0]), .Done(done[0]), .Fault(fault[0]));

  data_memory_unit #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .MemRd(req_rd && sel == 2'd1), .MemWr(req_wr && sel == 2'd1),
    .Size(req_size), .SignExt(req_sext), .Address(req_addr), .Data_in(req_din),
    .Data_out(dout1), .Busy(busy[1]), .Done(done[1]), .Fault(fault[1]));

  data_memory_unit #(.DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .MemRd(req_rd && sel == 2'd2), .MemWr(req_wr && sel == 2'd2),
    .Size(req_size), .SignExt(req_sext), .Address(req_addr), .Data_in(req_din),
    .Data_out(dout2), .Busy(busy[2]), .Done(done[2]), .Fault(fault[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int inst);
    case (inst)
      0:       return dout0;
      1:       return dout1;
      default: return dout2;
    endcase
  endfunction

  // Reference: memory as a flat byte array, little-endian, 256 bytes.
  task automatic model(input int inst, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] d,
                       output logic ef, output logic [31:0] ed);
    int n;
    logic [31:0] val;
    n  = 1 << sz;
    ef = (rd && wr) || sz == 2'b11 || (sz == 2'b01 && a[0]) ||
         (sz == 2'b10 && a[1:0] != 2'b00) || a >= 32'd256;
    if (ef) begin
      exp_dout[inst] = '0;
    end else if (wr) begin
      for (int i = 0; i < n; i++) mm[inst][a[7:0] + 8'(i)] = d[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) val = val | (32'(mm[inst][a[7:0] + 8'(i)]) << (8*i));
      if (sx && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      exp_dout[inst] = val;
    end
    ed = exp_dout[inst];
  endtask

  task automatic do_req(input int inst, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] d);
    int busy_n = 0, done_n = 0, done_at = 0, stray = 0;
    logic [31:0] got_d = '0;
    logic got_f = 1'b0;
    logic ef;
    logic [31:0] ed;
    model(inst, rd, wr, sz, sx, a, d, ef, ed);
    @(negedge clk);
    sel = 2'(inst); req_rd = rd; req_wr = wr; req_size = sz;
    req_sext = sx; req_addr = a; req_din = d;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      @(negedge clk);
      if (busy[inst]) busy_n++;
      if (fault[inst] && !done[inst]) stray++;
      if (done[inst]) begin
        done_n++; done_at = c; got_d = get_dout(inst); got_f = fault[inst];
      end
    end
    req_rd = 1'b0; req_wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (busy[inst])  busy_n++;
      if (done[inst])  done_n++;
      if (fault[inst]) stray++;
    end
    check($sformatf("latency i%0d a%h", inst, a), done_at, ws_of(inst) + 1);
    check($sformatf("busy_cycles i%0d a%h", inst, a), busy_n, ws_of(inst) + 1);
    check($sformatf("done_count i%0d a%h", inst, a), done_n, 1);
    check($sformatf("stray_fault i%0d a%h", inst, a), stray, 0);
    check($sformatf("fault i%0d a%h", inst, a), {31'd0, got_f}, {31'd0, ef});
    check($sformatf("data_out i%0d a%h", inst, a), got_d, ed);
  endtask

  task automatic check_idle_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s busy%0d", tag, i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("%s done%0d", tag, i), {31'd0, done[i]}, 32'd0);
      check($sformatf("%s fault%0d", tag, i), {31'd0, fault[i]}, 32'd0);
      check($sformatf("%s dout%0d", tag, i), get_dout(i), exp_dout[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 3; i++) begin
      exp_dout[i] = '0;
      for (int j = 0; j < 256; j++) mm[i][j] = 8'h00;
    end

    #1 check_idle_all("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_all("post_reset");

    // Word store/load, byte merge, sign extension (WS=1).
    do_req(0, 0, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF);
    do_req(0, 1, 0, 2'b10, 0, 32'h20, 32'h0);
    check("plan_word", dout0, 32'hDEADBEEF);
    do_req(0, 0, 1, 2'b10, 0, 32'h10, 32'h11223344);
    do_req(0, 0, 1, 2'b00, 0, 32'h12, 32'h000000AA);
    do_req(0, 1, 0, 2'b10, 0, 32'h10, 32'h0);
    check("plan_merge", dout0, 32'h11AA3344);
    do_req(0, 0, 1, 2'b10, 0, 32'h30, 32'h0000F080);
    do_req(0, 1, 0, 2'b01, 1, 32'h30, 32'h0);
    check("plan_half_sx", dout0, 32'hFFFFF080);
    do_req(0, 1, 0, 2'b01, 0, 32'h30, 32'h0);
    check("plan_half_zx", dout0, 32'h0000F080);
    do_req(0, 1, 0, 2'b00, 1, 32'h30, 32'h0);
    check("plan_byte_sx", dout0, 32'hFFFFFF80);

    // Faults: misaligned store, out-of-range load, read+write together.
    do_req(0, 0, 1, 2'b10, 0, 32'h22, 32'hCAFEF00D);
    do_req(0, 1, 0, 2'b10, 0, 32'h20, 32'h0);
    check("plan_fault_nowrite", dout0, 32'hDEADBEEF);
    do_req(0, 1, 0, 2'b10, 0, 32'h100, 32'h0);
    check("plan_oob_dout", dout0, 32'h0);
    do_req(0, 1, 1, 2'b10, 0, 32'h0, 32'h12345678);
    do_req(0, 1, 0, 2'b11, 0, 32'h4, 32'h0);

    // Latency at WS=0 and WS=3.
    do_req(1, 0, 1, 2'b01, 0, 32'h6, 32'h0000BEEF);
    do_req(1, 1, 0, 2'b01, 1, 32'h6, 32'h0);
    do_req(2, 0, 1, 2'b00, 0, 32'h41, 32'h0000007F);
    do_req(2, 1, 0, 2'b10, 0, 32'h40, 32'h0);

    // Reset in WAIT aborts a store and clears outputs without a clock edge.
    do_req(2, 0, 1, 2'b10, 0, 32'h40, 32'h12345678);
    do_req(2, 1, 0, 2'b10, 0, 32'h40, 32'h0);
    @(negedge clk);
    sel = 2'd2; req_rd = 1'b0; req_wr = 1'b1; req_size = 2'b10;
    req_sext = 1'b0; req_addr = 32'h40; req_din = 32'h5555AAAA;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 check("rst_busy_before", {31'd0, busy[2]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) exp_dout[i] = '0;
    check_idle_all("rst_wait");
    @(negedge clk);
    req_wr = 1'b0;
    reset = 1'b0;
    do_req(2, 1, 0, 2'b10, 0, 32'h40, 32'h0);
    check("rst_old_value", dout2, 32'h12345678);

    // Random traffic on all three instances.
    for (int k = 0; k < 60; k++) begin
      int inst;
      logic rd, wr;
      inst = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      rd = (r <= 4);
      wr = (r == 0) || (r >= 5);
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 2'b11 : 2'(r % 3);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      do_req(inst, rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    check_idle_all("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
